audio_lockstep_checker: RTL and testbench

AUDIO_LOCKSTEP_CHECKER -- requirements
Module: audio_lockstep_checker

---
 rtl/audio_lockstep_checker.sv | 119 +++++++++++
 tb/tb_audio_lockstep_checker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_lockstep_checker.sv
// audio_lockstep_checker: drains NUM_CH first-word-fall-through channel FIFOs
// in lockstep against an expected-value FIFO and tallies per-channel mismatches.
// Optional build macro: CHECKER_STOP_ON_ERROR_EN (end the run on the first mismatching pop).
module audio_lockstep_checker #(
  parameter int NUM_CH    = 2,
  parameter int DATA_SIZE = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [CNT_WIDTH-1:0]          sample_count,
  input  logic [NUM_CH-1:0]             ch_empty,
  output logic [NUM_CH-1:0]             ch_rd_en,
  input  logic [NUM_CH*DATA_SIZE-1:0]   ch_data,
  input  logic                          exp_empty,
  output logic                          exp_rd_en,
  input  logic [NUM_CH*DATA_SIZE-1:0]   exp_data,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_WIDTH-1:0]          error_count,
  output logic [CNT_WIDTH-1:0]          first_err_index,
  output logic [NUM_CH-1:0]             first_err_mask
);

  localparam int PCW = $clog2(NUM_CH + 1);

`ifdef CHECKER_STOP_ON_ERROR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] remaining;
  logic [CNT_WIDTH-1:0] sample_idx;
  logic                 err_seen;
  logic                 pop;
  logic                 launch;
  logic [NUM_CH-1:0]    mismatch;
  logic [PCW-1:0]       mm_cnt;
  logic [CNT_WIDTH:0]   err_sum;

  // Per-channel full-word compare and its population count
  always_comb begin
    mismatch = '0;
    mm_cnt   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      mismatch[c] = (ch_data[c*DATA_SIZE +: DATA_SIZE] != exp_data[c*DATA_SIZE +: DATA_SIZE]);
      mm_cnt      = mm_cnt + PCW'(mismatch[c]);
    end
  end

  // All FIFOs pop together or not at all
  assign pop       = (state == RUN) && (ch_empty == '0) && !exp_empty && (remaining != '0);
  assign ch_rd_en  = {NUM_CH{pop}};
  assign exp_rd_en = pop;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign launch    = start && (state != RUN);
  assign err_sum   = {1'b0, error_count} + (CNT_WIDTH+1)'(mm_cnt);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (sample_count == '0) ? DONE : RUN;
      end
      RUN: begin
        if (pop && ((remaining == CNT_WIDTH'(1)) || (STOP_ON_ERR && (mismatch != '0))))
          state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run bookkeeping: sample countdown, saturating error tally, first-error capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      remaining       <= '0;
      sample_idx      <= '0;
      err_seen        <= 1'b0;
      error_count     <= '0;
      first_err_index <= '0;
      first_err_mask  <= '0;
    end else if (launch) begin
      remaining       <= sample_count;
      sample_idx      <= '0;
      err_seen        <= 1'b0;
      error_count     <= '0;
      first_err_index <= '0;
      first_err_mask  <= '0;
    end else if (pop) begin
      remaining   <= remaining - CNT_WIDTH'(1);
      sample_idx  <= sample_idx + CNT_WIDTH'(1);
      error_count <= err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
      if (!err_seen && (mismatch != '0)) begin
        err_seen        <= 1'b1;
        first_err_index <= sample_idx;
        first_err_mask  <= mismatch;
      end
    end
  end

endmodule

// File: tb/tb_audio_lockstep_checker.sv
module tb_audio_lockstep_checker;

  localparam int NCH  = 2;
  localparam int DW   = 32;
  localparam int CW   = 16;
  localparam int MAXS = 1100;

`ifdef CHECKER_STOP_ON_ERROR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic              start;
  logic [CW-1:0]     sample_count;
  logic [NCH-1:0]    ch_empty;
  logic [NCH-1:0]    ch_rd_en;
  logic [NCH*DW-1:0] ch_data;
  logic              exp_empty;
  logic              exp_rd_en;
  logic [NCH*DW-1:0] exp_data;
  logic              busy;
  logic              done;
  logic [CW-1:0]     error_count;
  logic [CW-1:0]     first_err_index;
  logic [NCH-1:0]    first_err_mask;

  // Small-counter instance for saturation
  logic        start2;
  logic [3:0]  sample_count2;
  logic [1:0]  ch_empty2;
  logic [1:0]  ch_rd_en2;
  logic [15:0] ch_data2;
  logic        exp_empty2;
  logic        exp_rd_en2;
  logic [15:0] exp_data2;
  logic        busy2;
  logic        done2;
  logic [3:0]  error_count2;
  logic [3:0]  first_err_index2;
  logic [1:0]  first_err_mask2;

  audio_lockstep_checker #(.NUM_CH(NCH), .DATA_SIZE(DW), .CNT_WIDTH(CW)) u_dut (
    .clock(clock), .reset(reset), .start(start), .sample_count(sample_count),
    .ch_empty(ch_empty), .ch_rd_en(ch_rd_en), .ch_data(ch_data),
    .exp_empty(exp_empty), .exp_rd_en(exp_rd_en), .exp_data(exp_data),
    .busy(busy), .done(done), .error_count(error_count),
    .first_err_index(first_err_index), .first_err_mask(first_err_mask)
  );

  audio_lockstep_checker #(.NUM_CH(2), .DATA_SIZE(8), .CNT_WIDTH(4)) u_sat (
    .clock(clock), .reset(reset), .start(start2), .sample_count(sample_count2),
    .ch_empty(ch_empty2), .ch_rd_en(ch_rd_en2), .ch_data(ch_data2),
    .exp_empty(exp_empty2), .exp_rd_en(exp_rd_en2), .exp_data(exp_data2),
    .busy(busy2), .done(done2), .error_count(error_count2),
    .first_err_index(first_err_index2), .first_err_mask(first_err_mask2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ch_mem  [NCH][MAXS];
  logic [DW-1:0] exp_mem [NCH][MAXS];
  int ptr, pops, viol, cyc, mode;
  bit mid_start;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: walk the sample arrays and apply the checker's rules directly
  function automatic void ref_model(input int n, input int maxv, output int e_pops,
                                    output int e_errs, output int e_idx, output int e_mask);
    bit seen = 1'b0;
    e_pops = 0; e_errs = 0; e_idx = 0; e_mask = 0;
    for (int i = 0; i < n; i++) begin
      int mm = 0;
      int msk = 0;
      for (int c = 0; c < NCH; c++)
        if (ch_mem[c][i] != exp_mem[c][i]) begin
          mm++;
          msk |= (1 << c);
        end
      e_errs += mm;
      if (e_errs > maxv) e_errs = maxv;
      e_pops = i + 1;
      if (msk != 0 && !seen) begin
        seen = 1'b1; e_idx = i; e_mask = msk;
      end
      if (STOP && msk != 0) break;
    end
  endfunction

  // kind: 0 clean, 1 fixed corruption at 5/9, 2 random corruption, 3 corrupt at 3
  task automatic fill(input int n, input int kind);
    for (int i = 0; i < MAXS; i++)
      for (int c = 0; c < NCH; c++) begin
        exp_mem[c][i] = $urandom;
        ch_mem[c][i]  = exp_mem[c][i];
      end
    if (kind == 1) begin
      ch_mem[0][5] = ~ch_mem[0][5];
      ch_mem[0][9] = ch_mem[0][9] ^ 32'h8000_0000;
      ch_mem[1][9] = ch_mem[1][9] ^ 32'h0000_0001;
    end else if (kind == 2) begin
      for (int i = 0; i < n; i++)
        for (int c = 0; c < NCH; c++)
          if ($urandom_range(0, 7) == 0) ch_mem[c][i] ^= (32'h1 << $urandom_range(0, 31));
    end else if (kind == 3) begin
      ch_mem[1][3] = ~ch_mem[1][3];
    end
  endtask

  task automatic step(output bit popped, output bit dn);
    @(negedge clock);
    cyc++;
    ch_empty  = '0;
    exp_empty = 1'b0;
    if (mode == 1) ch_empty[1] = cyc[0];
    else if (mode == 2) begin
      for (int c = 0; c < NCH; c++) ch_empty[c] = ($urandom_range(0, 9) < 3);
      exp_empty = ($urandom_range(0, 9) < 3);
    end
    for (int c = 0; c < NCH; c++) begin
      ch_data[c*DW +: DW]  = (ptr < MAXS) ? ch_mem[c][ptr]  : '0;
      exp_data[c*DW +: DW] = (ptr < MAXS) ? exp_mem[c][ptr] : '0;
    end
    if (mid_start) begin
      start = 1'b1;
      sample_count = 3;
    end
    #1;
    popped = exp_rd_en && (&ch_rd_en);
    if ((|ch_rd_en || exp_rd_en) && !(popped && ch_empty == '0 && !exp_empty)) viol++;
    @(posedge clock);
    #1;
    start = 1'b0;
    mid_start = 1'b0;
    if (popped) begin
      ptr++;
      pops++;
    end
    dn = done;
  endtask

  task automatic run(input string tag, input int n, input int m, input int inject_at, input int abort_at);
    bit p, d;
    int first_pop, last_pop, done_at, ep, ee, ei, em;
    ptr = 0; pops = 0; viol = 0; cyc = 0; mode = m;
    first_pop = -1; last_pop = -1; done_at = -1;
    @(negedge clock);
    ch_empty = '1; exp_empty = 1'b1;
    sample_count = CW'(n);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    if (n == 0) begin
      check({tag, "_done"}, done, 1);
      check({tag, "_busy"}, busy, 0);
      mode = 0;
      for (int s = 0; s < 3; s++) step(p, d);
      check({tag, "_pops"}, pops, 0);
      check({tag, "_viol"}, viol, 0);
      return;
    end
    for (int s = 0; s < 4*n + 40; s++) begin
      if (s == inject_at) mid_start = 1'b1;
      step(p, d);
      if (p) begin
        if (first_pop < 0) first_pop = s;
        last_pop = s;
      end
      if (abort_at > 0 && pops == abort_at) begin
        ch_empty = '0; exp_empty = 1'b0;
        #1;
        check({tag, "_pre_busy"}, busy, 1);
        reset = 1'b0;
        #1;
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_done"}, done, 0);
        check({tag, "_rst_err"}, error_count, 0);
        check({tag, "_rst_fidx"}, first_err_index, 0);
        check({tag, "_rst_fmask"}, first_err_mask, 0);
        check({tag, "_rst_rd"}, {ch_rd_en, exp_rd_en}, 0);
        reset = 1'b1;
        mode = 0;
        for (int k = 0; k < 3; k++) step(p, d);
        check({tag, "_idle_pops"}, pops, abort_at);
        check({tag, "_idle_busy"}, {busy, done}, 0);
        return;
      end
      if (d) begin
        done_at = s;
        break;
      end
    end
    ref_model(n, (1 << CW) - 1, ep, ee, ei, em);
    check({tag, "_pops"}, pops, ep);
    check({tag, "_done_lat"}, done_at, last_pop);
    if (m == 0) check({tag, "_consec"}, last_pop - first_pop + 1, ep);
    check({tag, "_err"}, error_count, ee);
    check({tag, "_fidx"}, first_err_index, ei);
    check({tag, "_fmask"}, first_err_mask, em);
    check({tag, "_viol"}, viol, 0);
    check({tag, "_busy"}, {busy, done}, 2'b01);
  endtask

  initial begin
    int sat_pops;
    reset = 1'b0; start = 1'b0; sample_count = '0;
    ch_empty = '1; exp_empty = 1'b1; ch_data = '0; exp_data = '0;
    mid_start = 1'b0;
    start2 = 1'b0; sample_count2 = '0; ch_empty2 = '0; exp_empty2 = 1'b0;
    ch_data2 = 16'h0000; exp_data2 = 16'hA5A5;
    #12;
    check("reset_flags", {busy, done, ch_rd_en, exp_rd_en}, 0);
    check("reset_err", error_count, 0);
    check("reset_first", {first_err_index, first_err_mask}, 0);
    #10 reset = 1'b1;

    fill(1000, 0);
    run("clean1000", 1000, 0, -1, 0);
    fill(1000, 0);
    run("gated1000", 1000, 1, -1, 0);
    fill(20, 1);
    run("corrupt", 20, 0, -1, 0);
    check("corrupt_err_k", error_count, STOP ? 1 : 3);
    check("corrupt_pops_k", pops, STOP ? 6 : 20);
    check("corrupt_first_k", {first_err_index, first_err_mask}, {16'd5, 2'b01});
    fill(15, 0);
    run("restart_clean", 15, 2, -1, 0);
    run("zero", 0, 0, -1, 0);
    fill(20, 0);
    run("midstart", 20, 0, 4, 0);
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 80);
      fill(n, 2);
      run($sformatf("rand%0d", r), n, 2, -1, 0);
    end
    fill(1000, 0);
    run("abort", 1000, 0, -1, 500);

    // Saturation on a 4-bit counter: 10 samples, both channels wrong every time
    @(negedge clock);
    sample_count2 = 4'd10;
    start2 = 1'b1;
    @(posedge clock);
    #1;
    start2 = 1'b0;
    sat_pops = 0;
    for (int s = 0; s < 40; s++) begin
      @(negedge clock);
      #1;
      if (exp_rd_en2 && ch_rd_en2 == 2'b11) sat_pops++;
      @(posedge clock);
      #1;
      if (done2) break;
    end
    check("sat_done", done2, 1);
    check("sat_pops", sat_pops, STOP ? 1 : 10);
    check("sat_err", error_count2, STOP ? 2 : 15);
    check("sat_first", {first_err_index2, first_err_mask2}, {4'd0, 2'b11});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
